// File: rtl/debounce_switch_pkg.sv
// ---------------------------------------------------------------------------
// switch_pkg
//   Purpose : shared types and helpers for the push-button front-end stages
//             (debounce, edge detect, LED toggle and their siblings).
//   Latency : n/a (declarations only).
//   Backpr. : n/a (declarations only).
//
// Contents
//   sw_state_e     - 4-state debounce FSM encoding (2 bits).
//   sw_cnt_width() - width of the stability counter for a given limit.
// ---------------------------------------------------------------------------
package switch_pkg;

  // Debounce FSM states. The low bit marks "counting a candidate change".
  // The high bit marks "accepted level is high". o_Busy and the accepted level
  // are still kept in their own registers, so nothing downstream relies on
  // these encodings.
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    COUNT_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    COUNT_LOW   = 2'd3
  } sw_state_e;

  // Counter width for a debounce limit. The counter only ever holds
  // 0 .. limit-1, so $clog2(limit) bits are enough. The width is floored at
  // one bit so that degenerate limits still give a legal vector.
  function automatic int unsigned sw_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : switch_pkg

// File: rtl/debounce_switch_if.sv
// ---------------------------------------------------------------------------
// debounce_switch_if
//   Purpose : bundles the raw switch input and the debounced outputs of one
//             button channel.
//   Latency : n/a (wires only).
//   Backpr. : none; every signal is a level or a single-cycle pulse.
//
// Signals
//   i_Switch - raw asynchronous bouncing button level (toward the debouncer)
//   o_Switch - debounced level, registered
//   o_Rise   - one-cycle pulse on the accepted 0->1 change
//   o_Fall   - one-cycle pulse on the accepted 1->0 change
//   o_Busy   - a candidate level change is being counted
//
// Modports
//   master - the side that owns the button pin and consumes the results
//   slave  - the debouncer itself
// ---------------------------------------------------------------------------
interface debounce_switch_if;

  logic i_Switch;
  logic o_Switch;
  logic o_Rise;
  logic o_Fall;
  logic o_Busy;

  modport master (
    output i_Switch,
    input  o_Switch,
    input  o_Rise,
    input  o_Fall,
    input  o_Busy
  );

  modport slave (
    input  i_Switch,
    output o_Switch,
    output o_Rise,
    output o_Fall,
    output o_Busy
  );

endinterface : debounce_switch_if

// File: rtl/debounce_switch_sync.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Purpose : two-flop synchronizer that brings one asynchronous level into
//             the clock domain.
//   Latency : 2 clock edges from d_i to q_o.
//   Backpr. : none; free-running level path.
//
// Ports
//   clk_i - clock; rising edge
//   rst_i - synchronous, active-high reset; clears both flops to 0
//   d_i   - asynchronous input level
//   q_o   - synchronized level; the only output any logic may use
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  // meta_q can go metastable. Only sync_q leaves this module, so the first
  // flop has a full cycle to resolve.
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/debounce_switch.sv
// ---------------------------------------------------------------------------
// debounce_switch
//   Purpose : debounces one mechanical push-button. It produces a clean level
//             plus single-cycle rise and fall pulses for the edge-detect and
//             LED-toggle stages.
//   Latency : DEBOUNCE_LIMIT+2 edges from the first edge that samples a new
//             stable level to the o_Switch change. That is 2 edges for the
//             synchronizer and DEBOUNCE_LIMIT edges of agreement.
//   Backpr. : none; the outputs are levels and pulses that cannot be stalled.
//
// Ports
//   i_Clk - clock; all state updates on the rising edge
//   i_Rst - synchronous, active-high reset
//   sw    - debounce_switch_if.slave: i_Switch in; o_Switch, o_Rise, o_Fall,
//           o_Busy out, all driven straight from flops
//
// Parameter
//   DEBOUNCE_LIMIT - consecutive disagreeing synchronized cycles needed to
//                    accept a new level; must be 2 or more
// ---------------------------------------------------------------------------
module debounce_switch
  import switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  debounce_switch_if.slave  sw
);

  localparam int unsigned           CW     = sw_cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0]         LIM_M1 = CW'(DEBOUNCE_LIMIT - 1);
  localparam logic [CW-1:0]         ONE    = CW'(1);

  // -------------------------------------------------------------------------
  // Synchronizer. Nothing below looks at sw.i_Switch directly.
  // -------------------------------------------------------------------------
  logic sw_sync;

  sync_2ff u_sync (
    .clk_i (i_Clk),
    .rst_i (i_Rst),
    .d_i   (sw.i_Switch),
    .q_o   (sw_sync)
  );

  // -------------------------------------------------------------------------
  // Debounce FSM.
  // count_q holds the number of consecutive disagreeing sw_sync cycles seen
  // so far in a COUNT_* state. The change is accepted on the cycle that
  // would make it DEBOUNCE_LIMIT, so the counter tops out at LIMIT-1 and
  // cannot wrap.
  // -------------------------------------------------------------------------
  sw_state_e     state_q,  state_d;
  logic [CW-1:0] count_q,  count_d;
  logic          switch_q, switch_d;
  logic          rise_q,   rise_d;
  logic          fall_q,   fall_d;
  logic          busy_q,   busy_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    switch_d = switch_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;

    case (state_q)
      STABLE_LOW: begin
        switch_d = 1'b0;
        count_d  = '0;
        if (sw_sync) begin
          state_d = COUNT_HIGH;
          count_d = ONE;
        end
      end

      COUNT_HIGH: begin
        if (!sw_sync) begin
          // A single agreeing cycle throws the partial count away.
          state_d = STABLE_LOW;
          count_d = '0;
        end else if (count_q == LIM_M1) begin
          state_d  = STABLE_HIGH;
          count_d  = '0;
          switch_d = 1'b1;
          rise_d   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end

      STABLE_HIGH: begin
        switch_d = 1'b1;
        count_d  = '0;
        if (!sw_sync) begin
          state_d = COUNT_LOW;
          count_d = ONE;
        end
      end

      COUNT_LOW: begin
        if (sw_sync) begin
          state_d = STABLE_HIGH;
          count_d = '0;
        end else if (count_q == LIM_M1) begin
          state_d  = STABLE_LOW;
          count_d  = '0;
          switch_d = 1'b0;
          fall_d   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end

      default: begin
        state_d  = STABLE_LOW;
        count_d  = '0;
        switch_d = 1'b0;
      end
    endcase

    // Busy is registered alongside the state, so it tracks the state the FSM
    // is entering.
    busy_d = (state_d == COUNT_HIGH) || (state_d == COUNT_LOW);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q  <= STABLE_LOW;
      count_q  <= '0;
      switch_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      switch_q <= switch_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
    end
  end

  // The pulses are set only on the cycle that switch_q changes, so they line
  // up with the first cycle that shows the new level. Only one of them can be
  // set on a given transition.
  assign sw.o_Switch = switch_q;
  assign sw.o_Rise   = rise_q;
  assign sw.o_Fall   = fall_q;
  assign sw.o_Busy   = busy_q;

endmodule : debounce_switch

// File: tb/tb_debounce_switch.sv
module tb_debounce_switch;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  debounce_switch_if u_if ();

  debounce_switch #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .sw    (u_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] outs();
    return {u_if.o_Switch, u_if.o_Rise, u_if.o_Fall, u_if.o_Busy};
  endfunction

  // Downstream LED-toggle stage: flips on each accepted release.
  logic led_q = 1'b0;
  always @(posedge clk) if (u_if.o_Fall) led_q <= ~led_q;

  // ---------------- run-length reference model + scoreboard ----------------
  // The model tracks the two-stage delayed input and how many consecutive
  // cycles it has disagreed with the accepted level. It flips the level when
  // that run reaches LIMIT.
  typedef struct packed { logic osw, rise, fall, busy; } exp_t;
  exp_t sb_q[$];
  logic sb_en = 1'b0;

  logic m_meta = 0, m_sync = 0, m_out = 0;
  int   m_run = 0;
  logic md_out, md_rise, md_fall;
  int   md_run;

  always_comb begin
    md_out  = m_out;
    md_run  = 0;
    md_rise = 1'b0;
    md_fall = 1'b0;
    if (m_sync != m_out) begin
      if (m_run + 1 >= LIMIT) begin
        md_out  = ~m_out;
        md_rise = ~m_out;
        md_fall = m_out;
      end else begin
        md_run = m_run + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_meta <= 1'b0; m_sync <= 1'b0; m_out <= 1'b0; m_run <= 0;
      if (sb_en) sb_q.push_back('0);
    end else begin
      m_meta <= u_if.i_Switch;
      m_sync <= m_meta;
      m_out  <= md_out;
      m_run  <= md_run;
      if (sb_en) sb_q.push_back({md_out, md_rise, md_fall, md_run != 0});
    end
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("sb_outs", 32'(outs()), 32'(e));
      check("sb_rise_and_fall", 32'(u_if.o_Rise & u_if.o_Fall), 32'd0);
    end
  end

  // ---------------- directed vector table ----------------
  // Inputs are applied before an edge; expected {o_Switch,o_Rise,o_Fall,o_Busy}
  // are checked after that edge.
  typedef struct packed { logic rst; logic sw; logic [3:0] exp; } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic s, input logic [3:0] e);
    tbl.push_back('{r, s, e});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k, nrise, nfall, rise_at, cyc, runlen;
    logic val;
    logic pat[9];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // reset, rise after 6 edges, busy for the count cycles
    add(1,0,4'b0000);
    add(0,1,4'b0000); add(0,1,4'b0000); add(0,1,4'b0001); add(0,1,4'b0001);
    add(0,1,4'b0001); add(0,1,4'b1100); add(0,1,4'b1000);
    // 3-cycle low glitch: count reaches LIMIT-1 and is abandoned
    add(0,0,4'b1000); add(0,0,4'b1000); add(0,0,4'b1001); add(0,1,4'b1001);
    add(0,1,4'b1001); add(0,1,4'b1000); add(0,1,4'b1000);
    // held low: single fall pulse
    add(0,0,4'b1000); add(0,0,4'b1000); add(0,0,4'b1001); add(0,0,4'b1001);
    add(0,0,4'b1001); add(0,0,4'b0010); add(0,0,4'b0000);
    // rise, then reset during the pulse cycle; switch held high through release
    add(0,1,4'b0000); add(0,1,4'b0000); add(0,1,4'b0001); add(0,1,4'b0001);
    add(0,1,4'b0001); add(0,1,4'b1100); add(1,1,4'b0000);
    add(0,1,4'b0000); add(0,1,4'b0000); add(0,1,4'b0001); add(0,1,4'b0001);
    add(0,1,4'b0001); add(0,1,4'b1100); add(0,1,4'b1000);

    u_if.i_Switch = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      u_if.i_Switch = tbl[i].sw;
      step();
      check($sformatf("vec[%0d]", i), 32'(outs()), 32'(tbl[i].exp));
    end
    check("led_toggled_once", 32'(led_q), 32'd1);

    // ---- reset mid-count (count=2) ----
    rst = 1'b1; u_if.i_Switch = 1'b0; step();
    rst = 1'b0; repeat (3) step();
    u_if.i_Switch = 1'b1;
    k = 0;
    while (!u_if.o_Busy && k < 10) begin step(); k++; end
    check("midrst_busy_seen", 32'(u_if.o_Busy), 32'd1);
    step();
    check("midrst_count2_busy", 32'(outs()), 32'b0001);
    rst = 1'b1; step();
    check("midrst_all_zero", 32'(outs()), 32'd0);
    rst = 1'b0;
    k = 0;
    do begin step(); k++; end while (!u_if.o_Rise && k < 20);
    check("midrst_rise_latency", 32'(k), 32'd6);
    step();
    check("midrst_after_pulse", 32'(outs()), 32'b1000);

    // ---- bounce pattern then held high ----
    rst = 1'b1; u_if.i_Switch = 1'b0; step();
    rst = 1'b0; repeat (3) step();
    nrise = 0; nfall = 0; rise_at = -1;
    for (int n = 0; n < 20; n++) begin
      u_if.i_Switch = (n < 9) ? pat[n] : 1'b1;
      step();
      if (u_if.o_Rise) begin nrise++; rise_at = n; end
      if (u_if.o_Fall) nfall++;
    end
    check("bounce_rise_count", 32'(nrise), 32'd1);
    check("bounce_rise_edge", 32'(rise_at), 32'd10);
    check("bounce_fall_count", 32'(nfall), 32'd0);
    check("bounce_level", 32'(u_if.o_Switch), 32'd1);

    // ---- random runs of 1..10 cycles, checked against the model ----
    sb_en = 1'b1;
    cyc = 0;
    val = 1'b0;
    while (cyc < 10000) begin
      val = ~val;
      runlen = int'($urandom_range(1, 10));
      for (int r = 0; r < runlen; r++) begin
        u_if.i_Switch = val;
        step();
        cyc++;
      end
    end
    sb_en = 1'b0;
    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_debounce_switch
